// File: rtl/tcam_reg_write_decoder.sv
// Receiver for the TCAM configuration register bus. Register writes collect a
// key, a don't-care mask and an action into shadow registers; a GO write to the
// command register snapshots them into the entry outputs and hands the entry to
// the TCAM core, holding off further GO writes until the core reports done.
module tcam_reg_write_decoder #(
   parameter int LOOK_UP_DATA_WIDTH = 144,
   parameter int ACTION_WIDTH       = 24,
   parameter int REG_ADDR_BUS_WIDTH = 8,
   parameter int REG_DATA_BUS_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_reg_bus_we,
   input  logic [REG_ADDR_BUS_WIDTH-1:0] i_reg_bus_we_addr,
   input  logic [REG_DATA_BUS_WIDTH-1:0] i_reg_bus_we_din,
   input  logic                          i_reg_bus_we_din_v,
   output logic                          o_tcam_busy,
   output logic                          o_entry_valid,
   input  logic                          i_entry_ready,
   output logic [2:0]                    o_entry_cmd,
   output logic [LOOK_UP_DATA_WIDTH-1:0] o_entry_key,
   output logic [LOOK_UP_DATA_WIDTH-1:0] o_entry_mask,
   output logic [ACTION_WIDTH-1:0]       o_entry_action,
   input  logic                          i_tcam_done,
   output logic                          o_write_done,
   output logic                          o_err_drop
);

   localparam int LW = LOOK_UP_DATA_WIDTH;
   localparam int ACW = ACTION_WIDTH;
   localparam int AW = REG_ADDR_BUS_WIDTH;
   localparam int DW = REG_DATA_BUS_WIDTH;
   localparam int KEY_WORDS = (LW + DW - 1) / DW;
   localparam int ACT_WORDS = (ACW + DW - 1) / DW;

   localparam logic [AW-1:0] KEY_BASE  = AW'('h00);
   localparam logic [AW-1:0] MASK_BASE = AW'('h10);
   localparam logic [AW-1:0] ACT_BASE  = AW'('h20);
   localparam logic [AW-1:0] CMD_ADDR  = AW'('h30);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   // True when addr falls in the word window [base, base+cnt).
   function automatic logic in_range(input logic [AW-1:0] addr,
                                     input logic [AW-1:0] base,
                                     input logic [AW-1:0] cnt);
      return (addr >= base) && ((addr - base) < cnt);
   endfunction

   state_t          state, state_nxt;
   logic            complete;
   logic            wr_acc, key_sel, mask_sel, act_sel, go_wr, issue, drop;
   logic [AW-1:0]   key_off, mask_off, act_off;
   logic [LW-1:0]   key_sh, mask_sh;
   logic [ACW-1:0]  act_sh;
   logic [LW-1:0]   key_wmask, key_wdata, mask_wmask, mask_wdata;
   logic [ACW-1:0]  act_wmask, act_wdata;

   assign wr_acc   = i_reg_bus_we & i_reg_bus_we_din_v;
   assign key_sel  = wr_acc & in_range(i_reg_bus_we_addr, KEY_BASE, AW'(KEY_WORDS));
   assign mask_sel = wr_acc & in_range(i_reg_bus_we_addr, MASK_BASE, AW'(KEY_WORDS));
   assign act_sel  = wr_acc & in_range(i_reg_bus_we_addr, ACT_BASE, AW'(ACT_WORDS));
   assign go_wr    = wr_acc & (i_reg_bus_we_addr == CMD_ADDR) & i_reg_bus_we_din[DW-1];
   assign issue    = go_wr & (state == IDLE);
   assign drop     = go_wr & (state != IDLE);

   assign key_off  = i_reg_bus_we_addr - KEY_BASE;
   assign mask_off = i_reg_bus_we_addr - MASK_BASE;
   assign act_off  = i_reg_bus_we_addr - ACT_BASE;

   // Word lane enables and positioned data; bits shifted past the register
   // width fall off, which trims the partial top word for free.
   assign key_wmask  = LW'({DW{1'b1}}) << (32'(key_off) * DW);
   assign key_wdata  = LW'(i_reg_bus_we_din) << (32'(key_off) * DW);
   assign mask_wmask = LW'({DW{1'b1}}) << (32'(mask_off) * DW);
   assign mask_wdata = LW'(i_reg_bus_we_din) << (32'(mask_off) * DW);
   assign act_wmask  = ACW'({DW{1'b1}}) << (32'(act_off) * DW);
   assign act_wdata  = ACW'(i_reg_bus_we_din) << (32'(act_off) * DW);

   // Shadow registers: always writable, also while an entry is in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_sh  <= '0;
         mask_sh <= '0;
         act_sh  <= '0;
      end else begin
         if (key_sel)  key_sh  <= (key_sh & ~key_wmask) | (key_wdata & key_wmask);
         if (mask_sel) mask_sh <= (mask_sh & ~mask_wmask) | (mask_wdata & mask_wmask);
         if (act_sel)  act_sh  <= (act_sh & ~act_wmask) | (act_wdata & act_wmask);
      end
   end

   // Next-state logic; done together with the ready handshake skips WAIT.
   always_comb begin
      state_nxt = state;
      complete  = 1'b0;
      case (state)
         IDLE:  if (go_wr) state_nxt = ISSUE;
         ISSUE: begin
            if (i_entry_ready) begin
               if (i_tcam_done) begin
                  state_nxt = IDLE;
                  complete  = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (i_tcam_done) begin
               state_nxt = IDLE;
               complete  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered status. Busy rises with the issue and stays up for
   // the done-pulse cycle, so it falls one cycle after o_write_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         o_entry_valid <= 1'b0;
         o_tcam_busy   <= 1'b0;
         o_write_done  <= 1'b0;
         o_err_drop    <= 1'b0;
      end else begin
         state         <= state_nxt;
         o_entry_valid <= (state_nxt == ISSUE);
         o_tcam_busy   <= (state != IDLE) | (state_nxt != IDLE);
         o_write_done  <= complete;
         if (drop) o_err_drop <= 1'b1;
      end
   end

   // Entry snapshot, taken only on an accepted GO so it is frozen while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_entry_cmd    <= '0;
         o_entry_key    <= '0;
         o_entry_mask   <= '0;
         o_entry_action <= '0;
      end else if (issue) begin
         o_entry_cmd    <= i_reg_bus_we_din[2:0];
         o_entry_key    <= key_sh;
         o_entry_mask   <= mask_sh;
         o_entry_action <= act_sh;
      end
   end

endmodule

// File: tb/tb_tcam_reg_write_decoder.sv
// Directed bench for tcam_reg_write_decoder: a transaction-level model predicts
// every output each cycle, with literal expectations at key points.
module tb_tcam_reg_write_decoder;

   logic         clk = 1'b0;
   logic         rst, we, dv, ready, done;
   logic [7:0]   addr;
   logic [15:0]  din;
   logic         busy, valid, wdone, err;
   logic [2:0]   cmd;
   logic [143:0] key, mask;
   logic [23:0]  act;

   int n_cmp = 0;
   int n_fail = 0;

   localparam logic [143:0] KEY1 = 144'h001122334455_00AABBCCDDEE_81002123_0800;
   localparam logic [143:0] KEY1_BEEF = 144'h001122334455_00AABBCCDDEE_81002123_BEEF;
   localparam logic [143:0] KEY2 = 144'h8888_7777_6666_5555_4444_3333_2222_1111_0000;

   always #5 clk = ~clk;

   tcam_reg_write_decoder dut (
      .clk(clk), .rst(rst),
      .i_reg_bus_we(we), .i_reg_bus_we_addr(addr), .i_reg_bus_we_din(din),
      .i_reg_bus_we_din_v(dv),
      .o_tcam_busy(busy), .o_entry_valid(valid), .i_entry_ready(ready),
      .o_entry_cmd(cmd), .o_entry_key(key), .o_entry_mask(mask),
      .o_entry_action(act), .i_tcam_done(done), .o_write_done(wdone),
      .o_err_drop(err)
   );

   task automatic check(input string name, input logic [143:0] got, input logic [143:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [143:0] m_key, m_mask, e_key, e_mask;
   logic [31:0]  m_act;
   logic [23:0]  e_act;
   logic [2:0]   e_cmd;
   logic         m_pending, m_offered, m_pulse, m_err;
   logic         acc, go, finish;

   assign acc    = we & dv;
   assign go     = acc && (addr == 8'h30) && din[15];
   assign finish = m_pending && done && (!m_offered || ready);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_key <= '0; m_mask <= '0; m_act <= '0;
         e_key <= '0; e_mask <= '0; e_act <= '0; e_cmd <= '0;
         m_pending <= 1'b0; m_offered <= 1'b0; m_pulse <= 1'b0; m_err <= 1'b0;
      end else begin
         if (acc && addr < 8'h09) m_key[int'(addr)*16 +: 16] <= din;
         if (acc && addr >= 8'h10 && addr < 8'h19) m_mask[(int'(addr)-16)*16 +: 16] <= din;
         if (acc && (addr == 8'h20 || addr == 8'h21)) m_act[(int'(addr)-32)*16 +: 16] <= din;
         if (m_offered && ready) m_offered <= 1'b0;
         m_pulse <= finish;
         if (finish) m_pending <= 1'b0;
         if (go) begin
            if (!m_pending) begin
               m_pending <= 1'b1;
               m_offered <= 1'b1;
               e_key  <= m_key;
               e_mask <= m_mask;
               e_act  <= m_act[23:0];
               e_cmd  <= din[2:0];
            end else begin
               m_err <= 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      check("valid",  144'(valid), 144'(m_offered));
      check("busy",   144'(busy),  144'(m_pending | m_pulse));
      check("wdone",  144'(wdone), 144'(m_pulse));
      check("err",    144'(err),   144'(m_err));
      check("cmd",    144'(cmd),   144'(e_cmd));
      check("key",    key,         e_key);
      check("mask",   mask,        e_mask);
      check("action", 144'(act),   144'(e_act));
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      we = 1'b1; dv = 1'b1; addr = a; din = d;
      tick(1);
      we = 1'b0; dv = 1'b0; addr = 8'h00; din = 16'h0000;
   endtask

   task automatic pulse_done();
      done = 1'b1;
      tick(1);
      done = 1'b0;
   endtask

   logic [15:0] key1_words [9] = '{16'h0800, 16'h2123, 16'h8100, 16'hDDEE, 16'hBBCC,
                                   16'h00AA, 16'h4455, 16'h2233, 16'h0011};

   initial begin
      rst = 1'b1; we = 1'b0; dv = 1'b0; ready = 1'b0; done = 1'b0;
      addr = 8'h00; din = 16'h0000;
      tick(3);
      check("rst_valid", 144'(valid), 144'(0));
      check("rst_busy",  144'(busy),  144'(0));
      check("rst_key",   key,         144'(0));
      rst = 1'b0;
      tick(1);

      // 1: full entry, ready tied high, done three cycles after issue
      for (int i = 0; i < 9; i++) wr(8'(i), key1_words[i]);
      for (int i = 0; i < 9; i++) wr(8'h10 + 8'(i), 16'h0000);
      wr(8'h20, 16'h3456);
      wr(8'h21, 16'h0012);
      ready = 1'b1;
      wr(8'h30, 16'h8000);
      check("t1_valid", 144'(valid), 144'(1));
      check("t1_busy",  144'(busy),  144'(1));
      check("t1_key",   key,         KEY1);
      check("t1_mask",  mask,        144'(0));
      check("t1_act",   144'(act),   144'(24'h123456));
      check("t1_cmd",   144'(cmd),   144'(0));
      tick(2);
      pulse_done();
      check("t1_wdone", 144'(wdone), 144'(1));
      check("t1_busy_hold", 144'(busy), 144'(1));
      tick(1);
      check("t1_wdone_off", 144'(wdone), 144'(0));
      check("t1_busy_low",  144'(busy),  144'(0));

      // 2: ready held low for five cycles
      ready = 1'b0;
      wr(8'h30, 16'h8003);
      tick(5);
      check("t2_valid_held", 144'(valid), 144'(1));
      check("t2_cmd",        144'(cmd),   144'(3));
      check("t2_key",        key,         KEY1);
      ready = 1'b1;
      tick(1);
      check("t2_valid_off", 144'(valid), 144'(0));
      pulse_done();
      tick(1);

      // 3: GO while waiting is dropped; key write while waiting prepares the next entry
      wr(8'h30, 16'h8000);
      tick(1);
      wr(8'h30, 16'h8001);
      check("t3_err",   144'(err),   144'(1));
      check("t3_valid", 144'(valid), 144'(0));
      wr(8'h00, 16'hBEEF);
      check("t3_key_frozen", key, KEY1);
      pulse_done();
      tick(3);
      check("t3_err_sticky", 144'(err), 144'(1));
      wr(8'h30, 16'h8000);
      check("t3_key_next", key, KEY1_BEEF);
      pulse_done();                        // done with ready in the issue cycle
      check("t3_direct_done", 144'(wdone), 144'(1));
      tick(1);

      // 4: non-accepted writes and unmapped addresses
      ready = 1'b0;
      we = 1'b1; dv = 1'b0; addr = 8'h30; din = 16'h8000;
      tick(1);
      we = 1'b0; dv = 1'b1;
      tick(1);
      dv = 1'b0;
      wr(8'h09, 16'h1234);
      wr(8'h3F, 16'h8000);
      tick(1);
      check("t4_valid", 144'(valid), 144'(0));
      check("t4_busy",  144'(busy),  144'(0));

      // 5: top action word truncation; command write without GO
      ready = 1'b1;
      wr(8'h21, 16'hFFAB);
      wr(8'h30, 16'h0005);
      tick(2);
      check("t5_no_valid", 144'(valid), 144'(0));
      wr(8'h30, 16'h8000);
      check("t5_act", 144'(act), 144'(24'hAB3456));
      check("t5_cmd", 144'(cmd), 144'(0));
      check("t5_key", key,       KEY1_BEEF);
      tick(1);
      pulse_done();
      tick(1);

      // 6: reset mid-entry
      wr(8'h30, 16'h8002);
      tick(1);
      rst = 1'b1;
      #1;
      check("t6_valid", 144'(valid), 144'(0));
      check("t6_busy",  144'(busy),  144'(0));
      check("t6_err",   144'(err),   144'(0));
      check("t6_key",   key,         144'(0));
      check("t6_act",   144'(act),   144'(0));
      tick(2);
      rst = 1'b0;
      pulse_done();                        // stray done in idle
      check("t6_no_wdone", 144'(wdone), 144'(0));
      for (int i = 0; i < 9; i++) wr(8'(i), 16'h1111 * 16'(i));
      wr(8'h10, 16'h00FF);
      wr(8'h20, 16'h0001);
      ready = 1'b0;
      wr(8'h30, 16'h8007);
      check("t6_key_new",  key,         KEY2);
      check("t6_mask_new", mask,        144'h00FF);
      check("t6_act_new",  144'(act),   144'(24'h000001));
      check("t6_cmd_new",  144'(cmd),   144'(7));
      ready = 1'b1;
      tick(1);
      pulse_done();
      check("t6_wdone", 144'(wdone), 144'(1));
      tick(1);
      check("t6_busy_low", 144'(busy), 144'(0));
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
